// File: rtl/hwregs_pkg.sv
// Shared register offsets and helpers for the hwregs memory-mapped responder.
package hwregs_pkg;

  localparam logic [5:0]  HWREG_SEVEN_SEG = 6'h00;
  localparam logic [5:0]  HWREG_LEDR      = 6'h01;
  localparam logic [5:0]  HWREG_SW        = 6'h02;
  localparam logic [5:0]  HWREG_KEY       = 6'h03;
  localparam logic [5:0]  HWREG_UART_TX   = 6'h04;
  localparam logic [5:0]  HWREG_UART_RX   = 6'h05;
  localparam logic [5:0]  HWREG_TIMER     = 6'h06;

  localparam logic [31:0] HWREG_RX_EMPTY  = 32'hFFFF_FFFF;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/hwregs_fifo.sv
// Synchronous FIFO for UART transmit bytes; pointers carry an extra wrap bit.
module hwregs_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/hwregs.sv
// Hardware-register responder: LEDs, seven-seg, switches/keys, timer and UART
// TX FIFO / RX holding register, with a fixed one-cycle ack.
module hwregs
  import hwregs_pkg::*;
#(
  parameter int TX_DEPTH    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cpu_hwregs_req,
  input  logic        cpu_hwregs_write,
  input  logic [15:0] cpu_hwregs_addr,
  input  logic [3:0]  cpu_hwregs_wmask,
  input  logic [31:0] cpu_hwregs_wdata,
  output logic        cpu_hwregs_ack,
  output logic [31:0] cpu_hwregs_rdata,
  output logic [23:0] seven_seg,
  output logic [9:0]  ledr,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [SYNC_STAGES-1:0][9:0] sw_pipe;
  logic [SYNC_STAGES-1:0][3:0] key_pipe;
  logic [5:0]    reg_idx;
  logic          rd_req;
  logic          wr_req;
  logic          tx_push;
  logic          tx_full;
  logic          tx_empty;
  logic [CW-1:0] tx_count;
  logic          rx_read;
  logic          rx_held;
  logic [7:0]    rx_byte;
  logic [31:0]   timer;
  logic [31:0]   rdata_next;
  logic          unused_addr;

  assign reg_idx     = cpu_hwregs_addr[7:2];
  assign unused_addr = &{1'b0, cpu_hwregs_addr[15:8], cpu_hwregs_addr[1:0], tx_full};
  assign rd_req      = cpu_hwregs_req && !cpu_hwregs_write;
  assign wr_req      = cpu_hwregs_req &&  cpu_hwregs_write;
  assign tx_push     = wr_req && (reg_idx == HWREG_UART_TX) && cpu_hwregs_wmask[0];
  assign rx_read     = rd_req && (reg_idx == HWREG_UART_RX);

  hwregs_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (tx_push),
    .push_data (cpu_hwregs_wdata[7:0]),
    .pop       (uart_tx_ready),
    .head      (uart_tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign uart_tx_valid = !tx_empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_pipe  <= '0;
      key_pipe <= '0;
    end else begin
      sw_pipe[0]  <= sw;
      key_pipe[0] <= key;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_pipe[i]  <= sw_pipe[i-1];
        key_pipe[i] <= key_pipe[i-1];
      end
    end
  end

  always_comb begin
    rdata_next = '0;
    if (rd_req) begin
      case (reg_idx)
        HWREG_SEVEN_SEG: rdata_next = {8'h0, seven_seg};
        HWREG_LEDR:      rdata_next = {22'h0, ledr};
        HWREG_SW:        rdata_next = {22'h0, sw_pipe[SYNC_STAGES-1]};
        HWREG_KEY:       rdata_next = {28'h0, key_pipe[SYNC_STAGES-1]};
        HWREG_UART_TX:   rdata_next = 32'(TX_DEPTH) - 32'(tx_count);
        HWREG_UART_RX:   rdata_next = rx_held ? {24'h0, rx_byte} : HWREG_RX_EMPTY;
        HWREG_TIMER:     rdata_next = timer;
        default:         rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cpu_hwregs_ack   <= 1'b0;
      cpu_hwregs_rdata <= '0;
      seven_seg        <= '0;
      ledr             <= '0;
      timer            <= '0;
      rx_held          <= 1'b0;
      rx_byte          <= '0;
    end else begin
      cpu_hwregs_ack   <= cpu_hwregs_req;
      cpu_hwregs_rdata <= rdata_next;

      if (wr_req && reg_idx == HWREG_SEVEN_SEG) begin
        for (int b = 0; b < 3; b++)
          if (cpu_hwregs_wmask[b]) seven_seg[8*b +: 8] <= cpu_hwregs_wdata[8*b +: 8];
      end
      if (wr_req && reg_idx == HWREG_LEDR) begin
        if (cpu_hwregs_wmask[0]) ledr[7:0] <= cpu_hwregs_wdata[7:0];
        if (cpu_hwregs_wmask[1]) ledr[9:8] <= cpu_hwregs_wdata[9:8];
      end

      if (wr_req && reg_idx == HWREG_TIMER && |cpu_hwregs_wmask)
        timer <= byte_merge(timer, cpu_hwregs_wdata, cpu_hwregs_wmask);
      else
        timer <= timer + 32'd1;

      // A fresh byte wins over a same-cycle read clear; the read still sees the old byte.
      if (uart_rx_valid) begin
        rx_byte <= uart_rx_data;
        rx_held <= 1'b1;
      end else if (rx_read) begin
        rx_held <= 1'b0;
      end
    end
  end

endmodule

// File: doc/hwregs.md
# hwregs

Memory-mapped hardware-register responder occupying the 0xE000_0000 region of the CPU data bus. It receives single-cycle requests routed by the data-side address decoder and returns exactly one ack one cycle later. Its read data is OR-merged with other responders, so it drives zero when not acking. It owns LEDs, seven-segment digits, switch/key inputs, a free-running timer, an 8-entry UART transmit FIFO and a one-byte UART receive holding register.

## Interface
Parameters:
- TX_DEPTH, 8, UART TX FIFO depth in bytes; must be a power of two.
- SYNC_STAGES, 2, synchroniser flops on `sw` and `key`.

Ports:
- clock  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- cpu_hwregs_req  in  1  single-cycle request strobe from the address decoder.
- cpu_hwregs_write  in  1  1 = write, 0 = read; qualified by req.
- cpu_hwregs_addr  in  16  byte offset within the region; bits [1:0] ignored.
- cpu_hwregs_wmask  in  4  byte enables for writes.
- cpu_hwregs_wdata  in  32  write data.
- cpu_hwregs_ack  out  1  one-cycle acknowledge.
- cpu_hwregs_rdata  out  32  read data; 0 whenever ack is low.
- seven_seg  out  24  six 4-bit hex digits.
- ledr  out  10  LED drive.
- sw  in  10  asynchronous switches.
- key  in  4  asynchronous push buttons.
- uart_tx_valid  out  1  FIFO head byte available.
- uart_tx_data  out  8  FIFO head byte.
- uart_tx_ready  in  1  transmitter pops the head when valid && ready.
- uart_rx_valid  in  1  one-cycle pulse: new received byte.
- uart_rx_data  in  8  received byte.

## Operation
Register map (addr[7:2]; addr[15:8] ignored, so the map aliases every 256 bytes):
- 0x00 SEVEN_SEG: RW, bits [23:0], byte-masked write.
- 0x04 LEDR: RW, bits [9:0], byte-masked write.
- 0x08 SW: RO, synchronised switches in [9:0].
- 0x0C KEY: RO, synchronised keys in [3:0].
- 0x10 UART_TX: write with wmask[0] pushes wdata[7:0]; read returns free-slot count (0..TX_DEPTH).
- 0x14 UART_RX: read returns {24'h0, byte} and clears valid if holding valid, else 0xFFFF_FFFF.
- 0x18 TIMER: increments every clock and wraps 0xFFFF_FFFF to 0; byte-masked write loads wdata. On the write cycle the loaded value replaces the increment.
- Any other offset: write ignored, read returns 0, ack still given.

Boundary rules:
- Push when FIFO full with no pop in the same cycle: byte dropped silently, state unchanged.
- Push and pop in the same cycle: both occur, count unchanged, including when full. When empty, push only and count becomes 1; no bypass.
- RX byte arrives while holding valid: overwrite with the new byte, valid stays 1.
- RX read and rx_valid pulse in the same cycle: read returns the old byte, new byte captured, valid stays 1.
- Writes with wmask = 0: no effect, ack still given.

## Timing
- Request sampled at clock edge N; ack high and rdata valid during cycle N+1. Ack is never held.
- Back-to-back requests are supported: requests on every cycle produce ack on every following cycle.
- Read side effects (RX clear) and writes take effect at the same edge that raises ack.
- `sw` and `key` reads reflect pins from SYNC_STAGES+1 cycles earlier.
- uart_tx_valid is registered: a push at edge N makes it high from N+1.
- Reset values: ack 0, rdata 0, seven_seg 0, ledr 0, timer 0, FIFO empty, uart_tx_valid 0, uart_tx_data 0, RX valid 0, synchronisers 0.
- Reset asserted mid-access discards the pending ack. Reset is applied asynchronously; deassertion must be synchronous to clock at the system level.

## Structure
- Package `hwregs_pkg`: register offset localparams (HWREG_SEVEN_SEG … HWREG_TIMER) and the RX-empty constant 32'hFFFF_FFFF.
- Sub-module `hwregs_fifo`:
  - Parameterised synchronous FIFO with push/pop/full/empty/count.
  - Pointers one bit wider than log2(TX_DEPTH) for the full/empty distinction.
- Everything else is in `hwregs`.

## Test plan
- Reset, then read each register -> ack exactly 1 cycle after each req; SEVEN_SEG/LEDR/TIMER-start read 0; UART_TX reads 8; UART_RX reads 0xFFFF_FFFF; offset 0x40 reads 0.
- Write LEDR 0x3FF with wmask 4'b0001, read back -> 0x0FF; ledr pin = 0x0FF; rdata 0 on all non-ack cycles.
- Push 9 bytes with uart_tx_ready=0 -> free count 0, 9th byte dropped. Then ready=1 -> bytes 1..8 out in order, free count back to 8.
- FIFO full, push while ready=1 -> count stays full, pushed byte emerges last.
- rx_valid pulse 0x41, then 0x42 -> read returns 0x42, then 0xFFFF_FFFF. rx pulse 0x55 coincident with read of held 0x42 -> read 0x42, next read 0x55.
- Write TIMER 0xFFFF_FFFE, read 3 cycles later -> 0x0000_0001 (wrap). Toggle sw=0x155 -> SW read reflects it after 3 cycles. Assert resetn mid-request -> no ack.
